multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: MEM_WAIT_MAX, default 15, max cycles a memory access may wait for mem_ready before a timeout error (legal range 1..255).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 run  input  1  permits a new instruction fetch to start.
REQ-005 opcode  input  7  instruction[6:0] from the instruction register; valid from DECODE onward.
REQ-006 mem_ready  input  1  memory handshake, accepts current access this cycle.
REQ-007 branch_taken  input  1  branch condition from branch compare logic; valid in EXEC.
REQ-008 state  output  3  FSM state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERROR=5.
REQ-009 mem_req, mem_we, iord  output  1 each  memory request, write, address select (0=PC, 1=ALU result).
REQ-010 ir_write, pc_write, oldpc_write  output  1 each  IR load, PC load, old-PC capture.
REQ-011 pc_src  output  2  next-PC select: 0=PC+4, 1=old_pc+imm, 2=ALU result (JALR, bit0 cleared by datapath).
REQ-012 alu_src_a  output  2  0=rs1, 1=old_pc, 2=zero; alu_src_b  output  2  0=rs2, 1=imm, 2=constant 4.
REQ-013 alu_op  output  2  00=add, 01=compare, 10=funct-decoded; reg_write  output  1; wb_sel  output  2  0=ALU, 1=mem rdata, 2=old_pc+4.
REQ-014 retire  output  1  one-cycle pulse when an instruction completes; err_illegal, err_timeout  output  1 each  sticky error flags.

Function
REQ-015 Moore FSM; all control outputs are combinational decodes of state and latched opcode class only; unlisted outputs are 0 in each state.
REQ-016 FETCH: mem_req=run, iord=0; on run & mem_ready: ir_write=1, oldpc_write=1, pc_write=1, pc_src=0, next DECODE; otherwise stay.
REQ-017 DECODE: latch opcode class (R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111); any other opcode -> ERROR with err_illegal=1; else next EXEC.
REQ-018 EXEC R/I: alu_src_a=0, alu_src_b=0 (R) or 1 (I), alu_op=10, next WB.
REQ-019 EXEC LOAD/STORE: alu_src_a=0, alu_src_b=1, alu_op=00, next MEM.
REQ-020 EXEC BRANCH: alu_src_a=0, alu_src_b=0, alu_op=01; pc_write=branch_taken, pc_src=1; retire=1; next FETCH.
REQ-021 EXEC JAL: pc_write=1, pc_src=1, next WB; JALR: alu_src_a=0, alu_src_b=1, alu_op=00, pc_write=1, pc_src=2, next WB.
REQ-022 EXEC LUI: alu_src_a=2, alu_src_b=1; AUIPC: alu_src_a=1, alu_src_b=1; both alu_op=00, next WB.
REQ-023 MEM: mem_req=1, iord=1, mem_we=STORE; on mem_ready: STORE -> FETCH with retire=1, LOAD -> WB; otherwise stay.
REQ-024 WB: reg_write=1; wb_sel=1 for LOAD, 2 for JAL/JALR, 0 otherwise; retire=1; next FETCH.
REQ-025 Wait counter (8-bit) cleared on entry to FETCH or MEM and while run=0 in FETCH; increments each cycle mem_req=1 and mem_ready=0.
REQ-026 Counter reaching MEM_WAIT_MAX with mem_ready=0 -> ERROR, err_timeout=1; mem_ready in that same cycle wins (normal transition, no error).
REQ-027 ERROR: all control outputs 0, absorbing until reset; err flags hold.
REQ-028 run deasserted only gates FETCH start; an instruction already past FETCH completes.

Reset
REQ-029 reset_n low asynchronously forces state=FETCH, counter=0, opcode class=0, err_illegal=0, err_timeout=0; all outputs 0 except mem_req following run after release.
REQ-030 Reset asserted mid-access (FETCH/MEM) abandons it immediately; no retire or write pulse is produced.

Verification
REQ-031 ADD (0x002081B3), mem_ready=1 every cycle -> states 0,1,2,4; reg_write and retire high in cycle 4 only; 4 cycles per instruction.
REQ-032 LW with mem_ready delayed 3 cycles in MEM -> MEM held 4 cycles, mem_req=1, iord=1, mem_we=0 throughout; then WB with wb_sel=1.
REQ-033 BEQ with branch_taken=1 then 0 -> pc_write=1, pc_src=1 in EXEC for first, pc_write=0 for second; retire=1 both; next state FETCH.
REQ-034 Opcode 0x7F -> DECODE to ERROR, err_illegal=1, all controls 0 for 20 following cycles; reset_n pulse returns to FETCH with flags clear.
REQ-035 MEM_WAIT_MAX=4, mem_ready held 0 in FETCH with run=1 -> ERROR after 4 waiting cycles, err_timeout=1; repeat with mem_ready=1 in 4th cycle -> DECODE, no error.
REQ-036 reset_n low during MEM of SW with mem_ready=0 -> state=FETCH asynchronously, mem_we=0, no retire.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Handshake and control bundle between the multicycle controller and its datapath/memory.
interface multicycle_control_if;
  logic       run;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       branch_taken;

  logic [2:0] state;
  logic       mem_req;
  logic       mem_we;
  logic       iord;
  logic       ir_write;
  logic       pc_write;
  logic       oldpc_write;
  logic [1:0] pc_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       reg_write;
  logic [1:0] wb_sel;
  logic       retire;
  logic       err_illegal;
  logic       err_timeout;

  // Controller side
  modport master (
    input  run, opcode, mem_ready, branch_taken,
    output state, mem_req, mem_we, iord, ir_write, pc_write, oldpc_write, pc_src,
           alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, retire, err_illegal, err_timeout
  );

  // Datapath side
  modport slave (
    output run, opcode, mem_ready, branch_taken,
    input  state, mem_req, mem_we, iord, ir_write, pc_write, oldpc_write, pc_src,
           alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, retire, err_illegal, err_timeout
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle RV32I-style core: fetch/decode/exec/mem/wb sequencing,
// memory wait timeout and sticky illegal-opcode / timeout error reporting.
module multicycle_control #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input logic                  clk,
  input logic                  reset_n,
  multicycle_control_if.master bus
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StError  = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    ClsNone, ClsR, ClsI, ClsLoad, ClsStore, ClsBranch, ClsJal, ClsJalr, ClsLui, ClsAuipc
  } cls_e;

  localparam logic [8:0] WaitMax = 9'(MEM_WAIT_MAX);

  state_e     state_q, state_d;
  cls_e       cls_q, cls_d, op_cls;
  logic [7:0] cnt_q, cnt_d;
  logic       err_illegal_q, err_illegal_d;
  logic       err_timeout_q, err_timeout_d;
  logic       mem_req;
  logic       timeout;

  assign mem_req = ((state_q == StFetch) && bus.run) || (state_q == StMem);
  // Timeout fires on the wait cycle that would bring the counter to MEM_WAIT_MAX;
  // a ready in that cycle takes priority.
  assign timeout = mem_req && !bus.mem_ready && (({1'b0, cnt_q} + 9'd1) >= WaitMax);

  // Opcode to instruction class
  always_comb begin
    case (bus.opcode)
      7'b0110011: op_cls = ClsR;
      7'b0010011: op_cls = ClsI;
      7'b0000011: op_cls = ClsLoad;
      7'b0100011: op_cls = ClsStore;
      7'b1100011: op_cls = ClsBranch;
      7'b1101111: op_cls = ClsJal;
      7'b1100111: op_cls = ClsJalr;
      7'b0110111: op_cls = ClsLui;
      7'b0010111: op_cls = ClsAuipc;
      default:    op_cls = ClsNone;
    endcase
  end

  // State, class latch, wait counter and sticky error flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StFetch;
      cls_q         <= ClsNone;
      cnt_q         <= 8'd0;
      err_illegal_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cls_q         <= cls_d;
      cnt_q         <= cnt_d;
      err_illegal_q <= err_illegal_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    cls_d         = cls_q;
    err_illegal_d = err_illegal_q;
    err_timeout_d = err_timeout_q;
    case (state_q)
      StFetch: begin
        if (bus.run && bus.mem_ready) begin
          state_d = StDecode;
        end else if (timeout) begin
          state_d       = StError;
          err_timeout_d = 1'b1;
        end
      end
      StDecode: begin
        cls_d = op_cls;
        if (op_cls == ClsNone) begin
          state_d       = StError;
          err_illegal_d = 1'b1;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        case (cls_q)
          ClsLoad, ClsStore: state_d = StMem;
          ClsBranch:         state_d = StFetch;
          ClsR, ClsI, ClsJal, ClsJalr, ClsLui, ClsAuipc: state_d = StWb;
          default: begin
            state_d       = StError;
            err_illegal_d = 1'b1;
          end
        endcase
      end
      StMem: begin
        if (bus.mem_ready) begin
          state_d = (cls_q == ClsStore) ? StFetch : StWb;
        end else if (timeout) begin
          state_d       = StError;
          err_timeout_d = 1'b1;
        end
      end
      StWb:    state_d = StFetch;
      StError: state_d = StError;
      default: state_d = StError;
    endcase

    // Any state change restarts the wait count; so does an idle fetch.
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = 8'd0;
    end else if ((state_q == StFetch) && !bus.run) begin
      cnt_d = 8'd0;
    end else if (mem_req && !bus.mem_ready) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Control output decode
  always_comb begin
    bus.state       = state_q;
    bus.mem_req     = mem_req;
    bus.mem_we      = 1'b0;
    bus.iord        = 1'b0;
    bus.ir_write    = 1'b0;
    bus.pc_write    = 1'b0;
    bus.oldpc_write = 1'b0;
    bus.pc_src      = 2'd0;
    bus.alu_src_a   = 2'd0;
    bus.alu_src_b   = 2'd0;
    bus.alu_op      = 2'b00;
    bus.reg_write   = 1'b0;
    bus.wb_sel      = 2'd0;
    bus.retire      = 1'b0;
    bus.err_illegal = err_illegal_q;
    bus.err_timeout = err_timeout_q;
    case (state_q)
      StFetch: begin
        if (bus.run && bus.mem_ready) begin
          bus.ir_write    = 1'b1;
          bus.oldpc_write = 1'b1;
          bus.pc_write    = 1'b1;
        end
      end
      StExec: begin
        case (cls_q)
          ClsR: bus.alu_op = 2'b10;
          ClsI: begin
            bus.alu_src_b = 2'd1;
            bus.alu_op    = 2'b10;
          end
          ClsLoad, ClsStore: bus.alu_src_b = 2'd1;
          ClsBranch: begin
            bus.alu_op   = 2'b01;
            bus.pc_write = bus.branch_taken;
            bus.pc_src   = 2'd1;
            bus.retire   = 1'b1;
          end
          ClsJal: begin
            bus.pc_write = 1'b1;
            bus.pc_src   = 2'd1;
          end
          ClsJalr: begin
            bus.alu_src_b = 2'd1;
            bus.pc_write  = 1'b1;
            bus.pc_src    = 2'd2;
          end
          ClsLui: begin
            bus.alu_src_a = 2'd2;
            bus.alu_src_b = 2'd1;
          end
          ClsAuipc: begin
            bus.alu_src_a = 2'd1;
            bus.alu_src_b = 2'd1;
          end
          default: ;
        endcase
      end
      StMem: begin
        bus.iord   = 1'b1;
        bus.mem_we = (cls_q == ClsStore);
        bus.retire = (cls_q == ClsStore) && bus.mem_ready;
      end
      StWb: begin
        bus.reg_write = 1'b1;
        bus.retire    = 1'b1;
        case (cls_q)
          ClsLoad:         bus.wb_sel = 2'd1;
          ClsJal, ClsJalr: bus.wb_sel = 2'd2;
          default:         bus.wb_sel = 2'd0;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench: two controllers (default wait limit and a limit of 4) driven cycle by cycle.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic rst_a_n;
  logic rst_b_n;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  multicycle_control_if ia ();
  multicycle_control_if ib ();

  multicycle_control #(.MEM_WAIT_MAX(15)) dut_a (
    .clk     (clk),
    .reset_n (rst_a_n),
    .bus     (ia.master)
  );

  multicycle_control #(.MEM_WAIT_MAX(4)) dut_b (
    .clk     (clk),
    .reset_n (rst_b_n),
    .bus     (ib.master)
  );

  // {mem_req, mem_we, iord, ir_write, pc_write, oldpc_write, pc_src, alu_src_a, alu_src_b,
  //  alu_op, reg_write, wb_sel, retire}
  function automatic logic [17:0] pk(input logic mreq, input logic mwe, input logic iord,
                                     input logic irw, input logic pcw, input logic opw,
                                     input logic [1:0] pcs, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [1:0] aop,
                                     input logic rw, input logic [1:0] wbs, input logic ret);
    return {mreq, mwe, iord, irw, pcw, opw, pcs, sa, sb, aop, rw, wbs, ret};
  endfunction

  function automatic logic [17:0] ctl_a();
    return {ia.mem_req, ia.mem_we, ia.iord, ia.ir_write, ia.pc_write, ia.oldpc_write,
            ia.pc_src, ia.alu_src_a, ia.alu_src_b, ia.alu_op, ia.reg_write, ia.wb_sel,
            ia.retire};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [17:0] ec;
    #3;
    checks++; if (ia.state !== 3'd0) $display("FAIL reset_state: got %0d want 0", ia.state);
    else passes++;
    checks++; if (ctl_a() !== 18'd0) $display("FAIL reset_ctl: got %h want 0", ctl_a());
    else passes++;
    checks++;
    if ({ia.err_illegal, ia.err_timeout} !== 2'b00)
      $display("FAIL reset_flags: got %b want 00", {ia.err_illegal, ia.err_timeout});
    else passes++;
    ia.run = 1'b1;
    #1;
    ec = pk(1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 2'd0, 0);
    checks++; if (ctl_a() !== ec) $display("FAIL reset_memreq_run: got %h want %h", ctl_a(), ec);
    else passes++;
    ia.run = 1'b0;
    tick();
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    tick();
    checks++; if (ia.state !== 3'd0) $display("FAIL idle_state: got %0d want 0", ia.state);
    else passes++;
  endtask

  task automatic test_add();
    logic       run [5];
    logic       rdy [5];
    logic [2:0] es  [5];
    logic [17:0] ec [5];
    run = '{1, 0, 0, 0, 0};
    rdy = '{1, 0, 0, 0, 0};
    es  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    ec  = '{pk(1, 0, 0, 1, 1, 1, 2'd0, 2'd0, 2'd0, 2'd0, 0, 2'd0, 0),
            18'd0,
            pk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'b10, 0, 2'd0, 0),
            pk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 1, 2'd0, 1),
            18'd0};
    ia.opcode = 7'h33;  // low bits of ADD 0x002081B3
    for (int i = 0; i < 5; i++) begin
      ia.run = run[i];
      ia.mem_ready = rdy[i];
      #1;
      checks++;
      if (ia.state !== es[i]) $display("FAIL add_state[%0d]: got %0d want %0d", i, ia.state, es[i]);
      else passes++;
      checks++;
      if (ctl_a() !== ec[i]) $display("FAIL add_ctl[%0d]: got %h want %h", i, ctl_a(), ec[i]);
      else passes++;
      tick();
    end
  endtask

  task automatic test_load();
    logic       rdy [9];
    logic [2:0] es  [9];
    logic [17:0] ec [9];
    logic [17:0] mw;
    mw  = pk(1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 2'd0, 0);
    rdy = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
    es  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0};
    ec  = '{pk(1, 0, 0, 1, 1, 1, 2'd0, 2'd0, 2'd0, 2'd0, 0, 2'd0, 0),
            18'd0,
            pk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd1, 2'd0, 0, 2'd0, 0),
            mw, mw, mw, mw,
            pk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 1, 2'd1, 1),
            18'd0};
    ia.opcode = 7'h03;
    for (int i = 0; i < 9; i++) begin
      ia.run = (i == 0);
      ia.mem_ready = rdy[i];
      #1;
      checks++;
      if (ia.state !== es[i]) $display("FAIL lw_state[%0d]: got %0d want %0d", i, ia.state, es[i]);
      else passes++;
      checks++;
      if (ctl_a() !== ec[i]) $display("FAIL lw_ctl[%0d]: got %h want %h", i, ctl_a(), ec[i]);
      else passes++;
      tick();
    end
  endtask

  task automatic test_branch();
    logic       run [7];
    logic       bt  [7];
    logic [2:0] es  [7];
    logic [17:0] ec [7];
    logic [17:0] fg;
    fg  = pk(1, 0, 0, 1, 1, 1, 2'd0, 2'd0, 2'd0, 2'd0, 0, 2'd0, 0);
    run = '{1, 0, 0, 1, 0, 0, 0};
    bt  = '{0, 0, 1, 0, 0, 0, 0};
    es  = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd0};
    ec  = '{fg, 18'd0,
            pk(0, 0, 0, 0, 1, 0, 2'd1, 2'd0, 2'd0, 2'b01, 0, 2'd0, 1),
            fg, 18'd0,
            pk(0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0, 2'b01, 0, 2'd0, 1),
            18'd0};
    ia.opcode = 7'h63;
    for (int i = 0; i < 7; i++) begin
      ia.run = run[i];
      ia.mem_ready = run[i];
      ia.branch_taken = bt[i];
      #1;
      checks++;
      if (ia.state !== es[i]) $display("FAIL beq_state[%0d]: got %0d want %0d", i, ia.state, es[i]);
      else passes++;
      checks++;
      if (ctl_a() !== ec[i]) $display("FAIL beq_ctl[%0d]: got %h want %h", i, ctl_a(), ec[i]);
      else passes++;
      tick();
    end
    ia.branch_taken = 1'b0;
  endtask

  task automatic test_jal();
    logic [2:0] es [5];
    logic [17:0] ec [5];
    es = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    ec = '{pk(1, 0, 0, 1, 1, 1, 2'd0, 2'd0, 2'd0, 2'd0, 0, 2'd0, 0),
           18'd0,
           pk(0, 0, 0, 0, 1, 0, 2'd1, 2'd0, 2'd0, 2'd0, 0, 2'd0, 0),
           pk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 1, 2'd2, 1),
           18'd0};
    ia.opcode = 7'h6F;
    for (int i = 0; i < 5; i++) begin
      ia.run = (i == 0);
      ia.mem_ready = (i == 0);
      #1;
      checks++;
      if (ia.state !== es[i]) $display("FAIL jal_state[%0d]: got %0d want %0d", i, ia.state, es[i]);
      else passes++;
      checks++;
      if (ctl_a() !== ec[i]) $display("FAIL jal_ctl[%0d]: got %h want %h", i, ctl_a(), ec[i]);
      else passes++;
      tick();
    end
  endtask

  task automatic test_illegal();
    ia.opcode = 7'h7F;
    ia.run = 1'b1;
    ia.mem_ready = 1'b1;
    tick();
    #1;
    checks++; if (ia.state !== 3'd1) $display("FAIL ill_decode: got %0d want 1", ia.state);
    else passes++;
    ia.branch_taken = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (ia.state !== 3'd5) $display("FAIL ill_state[%0d]: got %0d want 5", i, ia.state);
      else passes++;
      checks++;
      if (ctl_a() !== 18'd0) $display("FAIL ill_ctl[%0d]: got %h want 0", i, ctl_a());
      else passes++;
      checks++;
      if ({ia.err_illegal, ia.err_timeout} !== 2'b10)
        $display("FAIL ill_flags[%0d]: got %b want 10", i, {ia.err_illegal, ia.err_timeout});
      else passes++;
      tick();
    end
    ia.branch_taken = 1'b0;
    rst_a_n = 1'b0;
    #1;
    checks++; if (ia.state !== 3'd0) $display("FAIL ill_rst_state: got %0d want 0", ia.state);
    else passes++;
    checks++; if (ia.err_illegal !== 1'b0) $display("FAIL ill_rst_flag: got %b want 0", ia.err_illegal);
    else passes++;
    ia.run = 1'b0;
    ia.mem_ready = 1'b0;
    rst_a_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_store();
    logic [17:0] ec;
    ia.opcode = 7'h23;
    ia.run = 1'b1;
    ia.mem_ready = 1'b1;
    tick();
    ia.run = 1'b0;
    ia.mem_ready = 1'b0;
    tick();
    tick();
    #1;
    ec = pk(1, 1, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 2'd0, 0);
    checks++; if (ia.state !== 3'd3) $display("FAIL sw_mem_state: got %0d want 3", ia.state);
    else passes++;
    checks++; if (ctl_a() !== ec) $display("FAIL sw_mem_ctl: got %h want %h", ctl_a(), ec);
    else passes++;
    #2;
    rst_a_n = 1'b0;
    #1;
    checks++; if (ia.state !== 3'd0) $display("FAIL sw_rst_state: got %0d want 0", ia.state);
    else passes++;
    checks++;
    if ({ia.mem_we, ia.retire} !== 2'b00)
      $display("FAIL sw_rst_we_retire: got %b want 00", {ia.mem_we, ia.retire});
    else passes++;
    checks++; if (ctl_a() !== 18'd0) $display("FAIL sw_rst_ctl: got %h want 0", ctl_a());
    else passes++;
    rst_a_n = 1'b1;
    tick();
  endtask

  task automatic test_timeout();
    ib.run = 1'b1;
    ib.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ib.state !== 3'd0) $display("FAIL to_wait_state[%0d]: got %0d want 0", i, ib.state);
      else passes++;
      tick();
    end
    checks++; if (ib.state !== 3'd5) $display("FAIL to_state: got %0d want 5", ib.state);
    else passes++;
    checks++;
    if ({ib.err_illegal, ib.err_timeout} !== 2'b01)
      $display("FAIL to_flags: got %b want 01", {ib.err_illegal, ib.err_timeout});
    else passes++;
    ib.run = 1'b0;
    rst_b_n = 1'b0;
    #1;
    rst_b_n = 1'b1;
    checks++; if (ib.err_timeout !== 1'b0) $display("FAIL to_rst_flag: got %b want 0", ib.err_timeout);
    else passes++;
    tick();
    ib.run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ib.mem_ready = (i == 3);
      tick();
    end
    checks++; if (ib.state !== 3'd1) $display("FAIL to_ready_state: got %0d want 1", ib.state);
    else passes++;
    checks++; if (ib.err_timeout !== 1'b0) $display("FAIL to_ready_flag: got %b want 0", ib.err_timeout);
    else passes++;
    ib.run = 1'b0;
    ib.mem_ready = 1'b0;
  endtask

  initial begin
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    ia.run = 1'b0;
    ia.opcode = 7'h00;
    ia.mem_ready = 1'b0;
    ia.branch_taken = 1'b0;
    ib.run = 1'b0;
    ib.opcode = 7'h33;
    ib.mem_ready = 1'b0;
    ib.branch_taken = 1'b0;
    test_reset();
    test_add();
    test_load();
    test_branch();
    test_jal();
    test_illegal();
    test_reset_mid_store();
    test_timeout();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
